// File: rtl/mips_decode_exec_unit.sv
// mips_decode_exec_unit
//   Single-cycle helper block for a 5-stage MIPS pipeline. It contains:
//   - the ID-stage main control decoder, driven from instr;
//   - the IF-stage PC+4 incrementer;
//   - the EX-stage 32-bit ALU;
//   - a registered copy of the ALU result and zero flag.
//   The decode, increment and ALU paths are purely combinational.
//
// Optional feature (macro EXT_ALU_OPS_EN):
//   - ALU op 011 computes A^B (otherwise it yields 0).
//   - R-type funct 100110 (xor) and 100111 (nor) both decode to ALU op 011
//     with reg_write=1. Otherwise they are treated as unknown functs.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset (registered path only)
//   instr             ID-stage instruction word
//   pc                current fetch PC
//   src_a, src_b      ALU operands
//   alu_control_e     ALU operation select for the EX stage
//   reg_dst .. jump   decoded control signals
//   alu_control_d     decoded ALU operation
//   pc_plus4          pc + 4, wrapping
//   alu_out, zero     combinational ALU result and its all-zero flag
//   alu_out_q, zero_q registered alu_out / zero (reset values 0 / 1)
module mips_decode_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [2:0]       alu_control_e,
  output logic             reg_dst,
  output logic             jump,
  output logic             branch,
  output logic             mem_read,
  output logic             mem_to_reg,
  output logic [2:0]       alu_control_d,
  output logic             reg_write,
  output logic             alu_src,
  output logic             mem_write,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic [WIDTH-1:0] alu_out_q,
  output logic             zero_q
);

  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic [WIDTH-1:0] alu_out_d;
  logic             zero_d;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  function automatic logic [WIDTH-1:0] alu_fn(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [2:0]       op
  );
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic [WIDTH-1:0]        r;
    a_s = a;
    b_s = b;
    case (op)
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      3'b010:  r = a + b;
      3'b100:  r = a & ~b;
      3'b101:  r = a | ~b;
      3'b110:  r = a - b;
      3'b111:  r = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
`ifdef EXT_ALU_OPS_EN
      3'b011:  r = a ^ b;
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  // Main control decoder; any opcode not listed leaves every control low,
  // so the instruction behaves as a NOP downstream.
  always_comb begin
    reg_dst       = 1'b0;
    alu_src       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    branch        = 1'b0;
    jump          = 1'b0;
    alu_control_d = 3'b010;
    case (opcode)
      6'b000000: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        case (funct)
          6'b100000: alu_control_d = 3'b010;
          6'b100010: alu_control_d = 3'b110;
          6'b100100: alu_control_d = 3'b000;
          6'b100101: alu_control_d = 3'b001;
          6'b101010: alu_control_d = 3'b111;
`ifdef EXT_ALU_OPS_EN
          // nor shares the xor encoding; the ALU has no nor operation.
          6'b100110, 6'b100111: alu_control_d = 3'b011;
`endif
          default: reg_write = 1'b0;
        endcase
      end
      6'b100011: begin
        alu_src    = 1'b1;
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        mem_read   = 1'b1;
      end
      6'b101011: begin
        alu_src   = 1'b1;
        mem_write = 1'b1;
      end
      6'b000100: begin
        branch        = 1'b1;
        alu_control_d = 3'b110;
      end
      6'b001000: begin
        alu_src   = 1'b1;
        reg_write = 1'b1;
      end
      6'b000010: jump = 1'b1;
      default: ;
    endcase
  end

  assign pc_plus4 = pc + WIDTH'(4);

  always_comb begin
    alu_out_d = alu_fn(src_a, src_b, alu_control_e);
    zero_d    = (alu_out_d == '0);
  end

  assign alu_out = alu_out_d;
  assign zero    = zero_d;

  // EX -> downstream register boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_out_q <= '0;
      zero_q    <= 1'b1;
    end else begin
      alu_out_q <= alu_out_d;
      zero_q    <= zero_d;
    end
  end

endmodule

// File: tb/tb_mips_decode_exec_unit.sv
module tb_mips_decode_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr, pc, src_a, src_b;
  logic [2:0]  alu_control_e;
  logic        reg_dst, jump, branch, mem_read, mem_to_reg, reg_write, alu_src, mem_write;
  logic [2:0]  alu_control_d;
  logic [31:0] pc_plus4, alu_out, alu_out_q;
  logic        zero, zero_q;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mips_decode_exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .instr(instr), .pc(pc), .src_a(src_a), .src_b(src_b),
    .alu_control_e(alu_control_e), .reg_dst(reg_dst), .jump(jump), .branch(branch),
    .mem_read(mem_read), .mem_to_reg(mem_to_reg), .alu_control_d(alu_control_d),
    .reg_write(reg_write), .alu_src(alu_src), .mem_write(mem_write), .pc_plus4(pc_plus4),
    .alu_out(alu_out), .zero(zero), .alu_out_q(alu_out_q), .zero_q(zero_q)
  );

  // Control bundle order: reg_dst, alu_src, mem_to_reg, reg_write, mem_read,
  // mem_write, branch, jump, alu_control_d[2:0]
  typedef struct { logic [31:0] instr; logic [10:0] ctrl; } dec_vec_t;
  typedef struct { logic [31:0] a; logic [31:0] b; logic [2:0] op; logic [31:0] res; } alu_vec_t;

  dec_vec_t dvec[13];
  alu_vec_t avec[11];

  function automatic logic [10:0] ctrl_now();
    return {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump, alu_control_d};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference decode, written directly from the instruction table.
  function automatic logic [10:0] model_decode(input logic [31:0] ins);
    logic [5:0] op = ins[31:26];
    logic [5:0] fn = ins[5:0];
    if (op == 6'd0) begin
      if (fn == 6'h20) return 11'b10010000_010;
      if (fn == 6'h22) return 11'b10010000_110;
      if (fn == 6'h24) return 11'b10010000_000;
      if (fn == 6'h25) return 11'b10010000_001;
      if (fn == 6'h2A) return 11'b10010000_111;
`ifdef EXT_ALU_OPS_EN
      if (fn == 6'h26 || fn == 6'h27) return 11'b10010000_011;
`endif
      return 11'b10000000_010;
    end
    if (op == 6'h23) return 11'b01111000_010;
    if (op == 6'h2B) return 11'b01000100_010;
    if (op == 6'h04) return 11'b00000010_110;
    if (op == 6'h08) return 11'b01010000_010;
    if (op == 6'h02) return 11'b00000001_010;
    return 11'b00000000_010;
  endfunction

  // Reference ALU using integer arithmetic.
  function automatic logic [31:0] model_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
      3'd4: return a & ~b;
      3'd5: return a | ~b;
      3'd6: return 32'((64'h1_0000_0000 + 64'(a) - 64'(b)) % 64'h1_0000_0000);
      3'd7: return (sa < sb) ? 32'd1 : 32'd0;
`ifdef EXT_ALU_OPS_EN
      3'd3: return a ^ b;
`endif
      default: return 32'd0;
    endcase
  endfunction

  logic [5:0] ops_list[7];
  logic [31:0] exp_r;

  initial begin
    dvec[0]  = '{32'h8C820004, 11'b01111000_010};
    dvec[1]  = '{32'h1085FFFE, 11'b00000010_110};
    dvec[2]  = '{32'h08000010, 11'b00000001_010};
    dvec[3]  = '{32'h00851022, 11'b10010000_110};
    dvec[4]  = '{32'h00851020, 11'b10010000_010};
    dvec[5]  = '{32'h00851024, 11'b10010000_000};
    dvec[6]  = '{32'h00851025, 11'b10010000_001};
    dvec[7]  = '{32'h0085102A, 11'b10010000_111};
    dvec[8]  = '{32'h0000003F, 11'b10000000_010};
    dvec[9]  = '{32'hFC000000, 11'b00000000_010};
    dvec[10] = '{32'hAC820004, 11'b01000100_010};
    dvec[11] = '{32'h20820004, 11'b01010000_010};
`ifdef EXT_ALU_OPS_EN
    dvec[12] = '{32'h00851026, 11'b10010000_011};
`else
    dvec[12] = '{32'h00851026, 11'b10000000_010};
`endif

    avec[0]  = '{32'd5, 32'd5, 3'b110, 32'd0};
    avec[1]  = '{32'hFFFFFFFF, 32'd1, 3'b111, 32'd1};
    avec[2]  = '{32'hFFFFFFFF, 32'd1, 3'b010, 32'd0};
    avec[3]  = '{32'hF0, 32'h3C, 3'b000, 32'h30};
    avec[4]  = '{32'hF0, 32'h3C, 3'b001, 32'hFC};
    avec[5]  = '{32'hF0, 32'h3C, 3'b100, 32'hC0};
    avec[6]  = '{32'hF0, 32'h3C, 3'b101, 32'hFFFFFFF3};
`ifdef EXT_ALU_OPS_EN
    avec[7]  = '{32'hF0, 32'h3C, 3'b011, 32'hCC};
`else
    avec[7]  = '{32'hF0, 32'h3C, 3'b011, 32'h0};
`endif
    avec[8]  = '{32'd1, 32'hFFFFFFFF, 3'b111, 32'd0};
    avec[9]  = '{32'd3, 32'd10, 3'b110, 32'hFFFFFFF9};
    avec[10] = '{32'h80000000, 32'h7FFFFFFF, 3'b111, 32'd1};

    ops_list = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02, 6'h3F};

    reset = 1'b1; instr = '0; pc = '0; src_a = '0; src_b = '0; alu_control_e = 3'b010;
    #2;
    check("reset_alu_out_q", alu_out_q, 0);
    check("reset_zero_q", zero_q, 1);

    // Combinational paths work while reset is held.
    for (int i = 0; i < 13; i++) begin
      instr = dvec[i].instr; #1;
      check($sformatf("decode_%0d", i), ctrl_now(), dvec[i].ctrl);
    end
    pc = 32'h10; #1; check("pc_plus4_10", pc_plus4, 32'h14);
    pc = 32'hFFFFFFFC; #1; check("pc_plus4_wrap", pc_plus4, 32'h0);
    for (int i = 0; i < 11; i++) begin
      src_a = avec[i].a; src_b = avec[i].b; alu_control_e = avec[i].op; #1;
      check($sformatf("alu_%0d", i), alu_out, avec[i].res);
      check($sformatf("zero_%0d", i), zero, avec[i].res == 0);
    end

    // Reset held across a clock edge keeps reset values.
    @(posedge clk); #1;
    check("reset_hold_q", alu_out_q, 0);
    check("reset_hold_zero_q", zero_q, 1);

    // Release; first capture on the following rising edge.
    @(negedge clk);
    reset = 1'b0; src_a = 32'd3; src_b = 32'd4; alu_control_e = 3'b010; #1;
    check("pre_capture_q", alu_out_q, 0);
    @(posedge clk); #1;
    check("capture_q", alu_out_q, 7);
    check("capture_zero_q", zero_q, 0);
    @(negedge clk);
    src_a = 32'd5; src_b = 32'd5; alu_control_e = 3'b110;
    @(posedge clk); #1;
    check("capture_zero_res_q", alu_out_q, 0);
    check("capture_zero_flag_q", zero_q, 1);
    @(negedge clk);
    src_a = 32'd1; src_b = 32'd2; alu_control_e = 3'b010;
    @(posedge clk); #1;
    check("capture3_q", alu_out_q, 3);

    // Asynchronous reset in mid-cycle.
    #2 reset = 1'b1; #1;
    check("async_reset_q", alu_out_q, 0);
    check("async_reset_zero_q", zero_q, 1);
    @(negedge clk);
    reset = 1'b0; src_a = 32'd3; src_b = 32'd4; alu_control_e = 3'b010;
    @(posedge clk); #1;
    check("after_async_q", alu_out_q, 7);
    check("after_async_zero_q", zero_q, 0);

    // Randomized stimulus against the reference model.
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      instr = $urandom;
      instr[31:26] = ops_list[$urandom_range(0, 6)];
      if ($urandom_range(0, 3) == 0) instr[31:26] = 6'($urandom);
      pc = $urandom;
      if ($urandom_range(0, 7) == 0) pc = 32'hFFFFFFFC;
      src_a = $urandom;
      src_b = ($urandom_range(0, 4) == 0) ? src_a : $urandom;
      alu_control_e = 3'($urandom);
      #1;
      exp_r = model_alu(src_a, src_b, alu_control_e);
      check("rnd_decode", ctrl_now(), model_decode(instr));
      check("rnd_pc_plus4", pc_plus4, 32'((64'(pc) + 4) % 64'h1_0000_0000));
      check("rnd_alu", alu_out, exp_r);
      check("rnd_zero", zero, exp_r == 0);
      @(posedge clk); #1;
      check("rnd_alu_q", alu_out_q, exp_r);
      check("rnd_zero_q", zero_q, exp_r == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
